// File: rtl/if_stage_ibuf.sv
// Instruction fetch stage with a small instruction buffer in front of the decode stage.
// One fetch per cycle goes into a 1-cycle-latency instruction SRAM. The responses are
// queued in a FIFO so that ID stalls do not stall the SRAM pipeline. The stage also
// handles branch redirects (the delay slot is preserved), WB exception flushes, and
// unaligned fetch addresses (an AdEL entry is queued and fetching stops).
module if_stage_ibuf #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter int          IBUF_DEPTH = 4,
    parameter int          FS_WD      = 102
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ds_allowin,
    input  logic [64:0]                       br_bus,
    input  logic                              ws_handle_ex,
    input  logic [31:0]                       ex_pc,
    output logic                              fs_to_ds_valid,
    output logic [FS_WD-1:0]                  fs_to_ds_bus,
    output logic                              inst_sram_en,
    output logic [3:0]                        inst_sram_wen,
    output logic [31:0]                       inst_sram_addr,
    output logic [31:0]                       inst_sram_wdata,
    input  logic [31:0]                       inst_sram_rdata,
    output logic [$clog2(IBUF_DEPTH+1)-1:0]   fs_ibuf_count
);

    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam logic [4:0] EX_ADEL = 5'h04;

    logic [FS_WD-1:0] mem [IBUF_DEPTH];
    logic [PW-1:0]    head;
    logic [CW-1:0]    count;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [31:0]      req_pc;
    logic [31:0]      br_target_saved;
    logic             stopped;
    logic             ds_pend;

    logic             br_taken;
    logic [31:0]      br_target;
    logic [31:0]      br_pc;
    logic [31:0]      ds_pc;
    logic [31:0]      head_pc;
    logic [CW:0]      occupancy;
    logic             credit;
    logic             aligned;
    logic             issue;
    logic             adel;
    logic             pop;
    logic             br_head;
    logic             br_infl;
    logic             br_now;
    logic [FS_WD-1:0] resp_entry;
    logic [FS_WD-1:0] adel_entry;

    logic [PW-1:0]    head_n;
    logic [CW-1:0]    kept;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic [FS_WD-1:0] push_data;
    logic [PW-1:0]    wr_idx;
    logic             inflight_n;
    logic [31:0]      req_pc_n;
    logic             stopped_n;
    logic             ds_pend_n;
    logic [31:0]      saved_n;

    // Circular index arithmetic that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [CW-1:0] off);
        int s;
        s = int'(base) + int'(off);
        if (s >= IBUF_DEPTH) s = s - IBUF_DEPTH;
        return PW'(s);
    endfunction

    assign br_taken  = br_bus[64];
    assign br_target = br_bus[63:32];
    assign br_pc     = br_bus[31:0];
    assign ds_pc     = br_pc + 32'd4;

    assign fs_to_ds_valid  = (count != '0);
    assign fs_to_ds_bus    = mem[head];
    assign head_pc         = mem[head][31:0];
    assign fs_ibuf_count   = count;

    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit    = occupancy < (CW+1)'(IBUF_DEPTH);
    assign aligned   = (req_pc[1:0] == 2'b00);

    assign issue = !reset && !stopped && aligned && credit;
    assign adel  = !reset && !stopped && !aligned && !inflight && credit;
    assign pop   = fs_to_ds_valid && ds_allowin;

    assign inst_sram_en    = issue;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_addr  = req_pc;
    assign inst_sram_wdata = 32'h0;

    assign br_head = br_taken && fs_to_ds_valid && (head_pc == ds_pc);
    assign br_infl = br_taken && !br_head && inflight && (inflight_pc == ds_pc);
    assign br_now  = br_taken && !br_head && !br_infl && issue && (req_pc == ds_pc);

    assign resp_entry = {1'b0, 5'd0, 32'd0, inst_sram_rdata, inflight_pc};
    assign adel_entry = {1'b1, EX_ADEL, req_pc, 32'd0, req_pc};

    // Decide what survives this cycle: exception flush wins over branch, branch keeps only the delay slot.
    always_comb begin
        head_n     = head;
        kept       = count;
        do_push    = 1'b0;
        push_data  = resp_entry;
        inflight_n = 1'b0;
        req_pc_n   = req_pc;
        stopped_n  = stopped;
        ds_pend_n  = ds_pend;
        saved_n    = br_target_saved;
        if (ws_handle_ex) begin
            kept      = '0;
            req_pc_n  = ex_pc;
            stopped_n = 1'b0;
            ds_pend_n = 1'b0;
        end else if (br_taken) begin
            stopped_n = 1'b0;
            ds_pend_n = 1'b0;
            req_pc_n  = br_target;
            if (br_head) begin
                if (pop) begin
                    head_n = wrap_add(head, CW'(1));
                    kept   = '0;
                end else begin
                    kept   = CW'(1);
                end
            end else if (br_infl) begin
                kept    = '0;
                do_push = 1'b1;
            end else if (br_now) begin
                kept       = '0;
                inflight_n = 1'b1;
            end else begin
                kept      = '0;
                req_pc_n  = ds_pc;
                ds_pend_n = 1'b1;
                saved_n   = br_target;
            end
        end else begin
            if (pop) begin
                head_n = wrap_add(head, CW'(1));
                kept   = count - CW'(1);
            end
            if (inflight) begin
                do_push = 1'b1;
            end else if (adel) begin
                do_push   = 1'b1;
                push_data = adel_entry;
                stopped_n = 1'b1;
            end
            if (issue) begin
                inflight_n = 1'b1;
                if (ds_pend) begin
                    req_pc_n  = br_target_saved;
                    ds_pend_n = 1'b0;
                end else begin
                    req_pc_n  = req_pc + 32'd4;
                end
            end
        end
        count_n = kept + CW'(do_push);
        wr_idx  = wrap_add(head_n, kept);
    end

    // Control state: pointers, occupancy, outstanding request and fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            count           <= '0;
            inflight        <= 1'b0;
            inflight_pc     <= 32'h0;
            req_pc          <= RESET_PC;
            br_target_saved <= 32'h0;
            stopped         <= 1'b0;
            ds_pend         <= 1'b0;
        end else begin
            head            <= head_n;
            count           <= count_n;
            inflight        <= inflight_n;
            if (issue) inflight_pc <= req_pc;
            req_pc          <= req_pc_n;
            br_target_saved <= saved_n;
            stopped         <= stopped_n;
            ds_pend         <= ds_pend_n;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Testbench for if_stage_ibuf: directed fetch/stall/branch/exception/AdEL scenarios,
// then a randomized run checked against an in-order instruction stream model.
module tb_if_stage_ibuf;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ds_allowin = 1'b0;
    logic [64:0]  br_bus = '0;
    logic         ws_handle_ex = 1'b0;
    logic [31:0]  ex_pc = '0;
    logic         fs_to_ds_valid;
    logic [101:0] fs_to_ds_bus;
    logic         inst_sram_en;
    logic [3:0]   inst_sram_wen;
    logic [31:0]  inst_sram_addr;
    logic [31:0]  inst_sram_wdata;
    logic [31:0]  inst_sram_rdata = '0;
    logic [2:0]   fs_ibuf_count;

    int n_cmp = 0;
    int n_fail = 0;

    // model of the program stream seen by ID
    logic [31:0] m_exp = RESET_PC;
    logic        m_pend = 1'b0;
    logic [31:0] m_ds = '0;
    logic [31:0] m_tgt = '0;
    logic        m_stopped = 1'b0;
    logic        m_adel_seen = 1'b0;
    logic        prev_ex = 1'b0;
    logic        popped_plain = 1'b0;
    logic [31:0] popped_pc = '0;
    logic        popped_ds = 1'b0;
    int          pops = 0;

    if_stage_ibuf #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH), .FS_WD(102)) dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .ws_handle_ex(ws_handle_ex), .ex_pc(ex_pc),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata), .fs_ibuf_count(fs_ibuf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
    endfunction

    // synchronous instruction memory with one cycle of read latency
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] v;
        v = $urandom;
        return {16'hbfc0, v[15:2], 2'b00};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the negedge, check any pop against the model, advance.
    task automatic applyStimulus(input logic allow, input logic br, input logic [31:0] bpc,
                                 input logic [31:0] btgt, input logic ex, input logic [31:0] epc);
        logic [101:0] exp_bus;
        ds_allowin   = allow;
        br_bus       = {br, btgt, bpc};
        ws_handle_ex = ex;
        ex_pc        = epc;
        #1;
        if (prev_ex) checkOutput("valid_after_ex", 128'(fs_to_ds_valid), 128'(0));
        prev_ex = ex;
        popped_plain = 1'b0;
        popped_ds = 1'b0;
        if (fs_to_ds_valid && allow) begin
            pops++;
            if (m_stopped) begin
                checkOutput("pop_after_adel", 128'(fs_to_ds_valid), 128'(0));
            end else if (m_exp[1:0] != 2'b00) begin
                exp_bus = {1'b1, 5'h04, m_exp, 32'h0, m_exp};
                checkOutput("adel_entry", 128'(fs_to_ds_bus), 128'(exp_bus));
                m_stopped = 1'b1;
                m_adel_seen = 1'b1;
            end else begin
                exp_bus = {1'b0, 5'h00, 32'h0, inst_of(m_exp), m_exp};
                checkOutput("pop_entry", 128'(fs_to_ds_bus), 128'(exp_bus));
                popped_plain = 1'b1;
                popped_pc = m_exp;
                popped_ds = m_pend && (m_exp == m_ds);
                if (popped_ds) begin
                    m_exp = m_tgt;
                    m_pend = 1'b0;
                end else begin
                    m_exp = m_exp + 32'd4;
                end
            end
        end
        if (ex) begin
            m_exp = epc;
            m_pend = 1'b0;
            m_stopped = 1'b0;
        end else if (br) begin
            m_ds = bpc + 32'd4;
            m_exp = bpc + 32'd4;
            m_tgt = btgt;
            m_pend = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] tgt;
        int en_seen;
        int k;
        logic do_br;
        logic [31:0] br_pc_r;
        int stop_wait;

        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 128'(fs_to_ds_valid), 128'(0));
        checkOutput("rst_en", 128'(inst_sram_en), 128'(0));
        checkOutput("rst_count", 128'(fs_ibuf_count), 128'(0));
        checkOutput("rst_addr", 128'(inst_sram_addr), 128'(RESET_PC));

        // sequential fetch and first-entry latency
        reset = 1'b0;
        #1;
        checkOutput("en_t0", 128'(inst_sram_en), 128'(1));
        checkOutput("addr_t0", 128'(inst_sram_addr), 128'(RESET_PC));
        checkOutput("wen", 128'(inst_sram_wen), 128'(0));
        checkOutput("wdata", 128'(inst_sram_wdata), 128'(0));
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("valid_t1", 128'(fs_to_ds_valid), 128'(0));
        checkOutput("addr_t1", 128'(inst_sram_addr), 128'(RESET_PC + 32'd4));
        checkOutput("en_t1", 128'(inst_sram_en), 128'(1));
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("valid_t2", 128'(fs_to_ds_valid), 128'(1));
        checkOutput("pc_t2", 128'(fs_to_ds_bus[31:0]), 128'(RESET_PC));
        checkOutput("addr_t2", 128'(inst_sram_addr), 128'(RESET_PC + 32'd8));
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 0);

        // ID stall fills the buffer exactly, then fetch stops
        repeat (10) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_count", 128'(fs_ibuf_count), 128'(DEPTH));
        checkOutput("full_en", 128'(inst_sram_en), 128'(0));

        // branch with the delay slot at the buffer head
        p = m_exp;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, p, 32'hbfc00100, 0, 0);
        checkOutput("br_keep_count", 128'(fs_ibuf_count), 128'(1));
        checkOutput("br_keep_pc", 128'(fs_to_ds_bus[31:0]), 128'(p + 32'd4));
        repeat (8) applyStimulus(1, 0, 0, 0, 0, 0);

        // branch with nothing buffered and nothing in flight
        applyStimulus(0, 0, 0, 0, 1, 32'hbfc00200);
        checkOutput("ex1_addr", 128'(inst_sram_addr), 128'(32'hbfc00200));
        applyStimulus(0, 1, 32'hbfc00020, 32'hbfc00300, 0, 0);
        checkOutput("ds_fetch_en", 128'(inst_sram_en), 128'(1));
        checkOutput("ds_fetch_addr", 128'(inst_sram_addr), 128'(32'hbfc00024));
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("tgt_fetch_addr", 128'(inst_sram_addr), 128'(32'hbfc00300));
        repeat (8) applyStimulus(1, 0, 0, 0, 0, 0);

        // exception flush with entries buffered and a response in flight
        k = 0;
        while (fs_ibuf_count != 3'd3 && k < 12) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            k++;
        end
        checkOutput("reach_three", 128'(fs_ibuf_count), 128'(3));
        applyStimulus(0, 0, 0, 0, 1, 32'hbfc00380);
        checkOutput("ex_en", 128'(inst_sram_en), 128'(1));
        checkOutput("ex_addr", 128'(inst_sram_addr), 128'(32'hbfc00380));
        repeat (6) applyStimulus(1, 0, 0, 0, 0, 0);

        // branch to an unaligned target raises AdEL and stops fetching
        k = 0;
        while (!fs_to_ds_valid && k < 8) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            k++;
        end
        p = m_exp;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, p, 32'hbfc00102, 0, 0);
        en_seen = 0;
        repeat (10) begin
            en_seen += int'(inst_sram_en);
            applyStimulus(1, 0, 0, 0, 0, 0);
        end
        checkOutput("adel_no_fetch", 128'(en_seen), 128'(0));
        checkOutput("adel_seen", 128'(m_adel_seen), 128'(1));
        checkOutput("adel_drained", 128'(fs_to_ds_valid), 128'(0));
        applyStimulus(0, 0, 0, 0, 1, rand_pc());

        // randomized traffic
        do_br = 1'b0;
        br_pc_r = '0;
        stop_wait = 0;
        pops = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (do_br) begin
                tgt = rand_pc();
                if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'b10;
                applyStimulus(0, 1, br_pc_r, tgt, 0, 0);
                do_br = 1'b0;
            end else if ((m_stopped && stop_wait >= 6) || $urandom_range(0, 80) == 0) begin
                applyStimulus(0, 0, 0, 0, 1, rand_pc());
                stop_wait = 0;
            end else begin
                applyStimulus(logic'($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0);
                if (popped_plain && !popped_ds && $urandom_range(0, 4) == 0) begin
                    do_br = 1'b1;
                    br_pc_r = popped_pc;
                end
                if (m_stopped) stop_wait++;
            end
        end
        checkOutput("progress", 128'(pops > 500), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
